// File: rtl/gray_ptr_counter.sv
// gray_ptr_counter: up/down binary+Gray pointer counter with optional remote Gray pointer receiver
// Optional feature macro: GRAY_PTR_SYNC_EN enables the remote_gray_i synchroniser and converter.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   en, dir         step enable; dir 0 = increment, 1 = decrement
//   load, load_val  synchronous load of a binary value (beats en)
//   bin_o, gray_o   registered binary pointer and its Gray encoding
//   wrap_o          one-cycle pulse after a step that crossed the wrap point
//   remote_gray_i   Gray pointer from the other clock domain
//   remote_bin_o    synchronised remote pointer in binary (0 without GRAY_PTR_SYNC_EN)
module gray_ptr_counter #(
    parameter int WIDTH       = 4,
    parameter int INIT        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             wrap_o,
    input  logic [WIDTH-1:0] remote_gray_i,
    output logic [WIDTH-1:0] remote_bin_o
);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] INIT_BIN = WIDTH'(INIT);
    logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d;
    logic             wrap_q, wrap_d;
    // Gray is encoded from the next binary value so both registers change on the same edge.
    always_comb begin
        bin_d  = load ? load_val : en ? (dir ? bin_q - ONE : bin_q + ONE) : bin_q;
        gray_d = bin_d ^ (bin_d >> 1);
        wrap_d = !load && en && (dir ? bin_q == '0 : bin_q == '1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_BIN ^ (INIT_BIN >> 1);
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end
    assign bin_o  = bin_q;
    assign gray_o = gray_q;
    assign wrap_o = wrap_q;
`ifdef GRAY_PTR_SYNC_EN
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] rbin_q, rbin_d;
    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        rbin_d = '0;
        for (int i = 0; i < WIDTH; i++) rbin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            rbin_q <= '0;
        end else begin
            sync_q[0] <= remote_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            rbin_q <= rbin_d;
        end
    end
    assign remote_bin_o = rbin_q;
`else
    logic unused_remote;
    assign unused_remote = ^remote_gray_i;
    assign remote_bin_o  = '0;
`endif
endmodule
